// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, execute (redirect) and decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues word fetches, buffers two slots in a ring for decode.
// Slot states:
//   EMPTY   | slot free
//   PENDING | request granted, waiting for the memory response
//   FULL    | instruction captured, presented to decode when at head
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } slot_state_e;

  slot_state_e st_q[2];
  slot_state_e st_d[2];
  logic [31:0] slot_pc_q[2];
  logic [31:0] slot_pc_d[2];
  logic [31:0] slot_instr_q[2];
  logic [31:0] slot_instr_d[2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic        fill_q, fill_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] pc_q, pc_d;

  logic [1:0]  occ;
  logic [1:0]  pend;
  logic        pop;
  logic        grant;
  logic [2:0]  budget;

  always_comb begin
    occ  = 2'd0;
    pend = 2'd0;
    for (int i = 0; i < 2; i++) begin
      if (st_q[i] != EMPTY)   occ  = occ + 2'd1;
      if (st_q[i] == PENDING) pend = pend + 2'd1;
    end
  end

  assign bus.instr_valid = (st_q[head_q] == FULL);
  assign bus.instr       = slot_instr_q[head_q];
  assign bus.pc          = slot_pc_q[head_q];
  assign bus.imem_addr   = pc_q;

  assign pop = bus.instr_valid & bus.instr_ready;

  // Slots freed by this cycle's pop can be refilled immediately; discarded
  // in-flight responses still occupy memory capacity.
  assign budget       = {1'b0, occ} + {1'b0, drop_q} - {2'b00, pop};
  assign bus.imem_req = !bus.redirect && (budget < 3'd2);
  assign grant        = bus.imem_req & bus.imem_gnt;

  always_comb begin
    st_d         = st_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    fill_d       = fill_q;
    drop_d       = drop_q;
    pc_d         = pc_q;

    if (bus.redirect) begin
      for (int i = 0; i < 2; i++) st_d[i] = EMPTY;
      head_d = 1'b0;
      tail_d = 1'b0;
      fill_d = 1'b0;
      pc_d   = bus.redirect_pc & ~32'd3;
      drop_d = drop_q + pend - {1'b0, bus.imem_rvalid};
    end else begin
      if (pop) begin
        st_d[head_q] = EMPTY;
        head_d       = ~head_q;
      end
      if (bus.imem_rvalid) begin
        if (drop_q != 2'd0) begin
          drop_d = drop_q - 2'd1;
        end else begin
          st_d[fill_q]         = FULL;
          slot_instr_d[fill_q] = bus.imem_rdata;
          fill_d               = ~fill_q;
        end
      end
      // Applied last: with both slots busy and a pop, tail aliases the freed head slot.
      if (grant) begin
        st_d[tail_q]      = PENDING;
        slot_pc_d[tail_q] = pc_q;
        tail_d            = ~tail_q;
        pc_d              = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]         <= EMPTY;
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
      head_q <= 1'b0;
      tail_q <= 1'b0;
      fill_q <= 1'b0;
      drop_q <= 2'd0;
      pc_q   <= RESET_PC;
    end else begin
      st_q         <= st_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fill_q       <= fill_d;
      drop_q       <= drop_d;
      pc_q         <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency plus vector table.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   lat = 1;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Instruction memory: in-order, each response due lat cycles after its grant
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t q[$];
  int   cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0;
    end else begin
      cyc++;
      if (bus.imem_rvalid && q.size() > 0) void'(q.pop_front());
      if (bus.imem_req && bus.imem_gnt) q.push_back('{bus.imem_addr, cyc + lat - 1});
      checks++;
      if (q.size() > 2) begin
        errors++;
        $display("FAIL outstanding: got %0d required <= 2", q.size());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || q.size() == 0 || q[0].due > cyc) begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(q[0].addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    lat = l;
    #2 rst_n = 1'b1;
  endtask

  task automatic step(input logic g, input logic r, input logic rd, input logic [31:0] rp);
    @(negedge clk);
    bus.imem_gnt    = g;
    bus.instr_ready = r;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic ereq, input logic [31:0] eaddr);
    chk({tag, " valid"}, {31'd0, bus.instr_valid}, {31'd0, ev});
    chk({tag, " req"}, {31'd0, bus.imem_req}, {31'd0, ereq});
    chk({tag, " addr"}, bus.imem_addr, eaddr);
    if (ev) begin
      chk({tag, " pc"}, bus.pc, epc);
      chk({tag, " instr"}, bus.instr, mem_word(epc));
    end
  endtask

  typedef struct {
    bit          rst;
    int          lat;
    bit          gnt;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    bit          ereq;
    logic [31:0] eaddr;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit rst, int l, bit g, bit r, bit rd, logic [31:0] rp,
                              bit ev, logic [31:0] epc, bit ereq, logic [31:0] eaddr);
    vecs.push_back('{rst, l, g, r, rd, rp, ev, epc, ereq, eaddr});
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #1;
    chk("reset valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("reset instr", bus.instr, 32'd0);
    chk("reset pc", bus.pc, 32'd0);
    chk("reset addr", bus.imem_addr, 32'd0);

    // Streaming with 1-cycle memory, then ready low for 5 cycles
    add(1,1, 1,1,0,0, 0,32'h00, 1,32'h00);
    add(0,1, 1,1,0,0, 0,32'h00, 1,32'h04);
    add(0,1, 1,1,0,0, 1,32'h00, 1,32'h08);
    add(0,1, 1,1,0,0, 1,32'h04, 1,32'h0C);
    add(0,1, 1,1,0,0, 1,32'h08, 1,32'h10);
    add(0,1, 1,1,0,0, 1,32'h0C, 1,32'h14);
    for (int i = 0; i < 5; i++) add(0,1, 1,0,0,0, 1,32'h10, 0,32'h18);
    add(0,1, 1,1,0,0, 1,32'h10, 1,32'h18);
    add(0,1, 1,1,0,0, 1,32'h14, 1,32'h1C);
    add(0,1, 1,1,0,0, 1,32'h18, 1,32'h20);
    add(0,1, 1,1,0,0, 1,32'h1C, 1,32'h24);
    // Redirect to 0x100 with two fetches pending, 3-cycle memory
    add(1,3, 1,1,0,0,         0,32'h000, 1,32'h000);
    add(0,3, 1,1,0,0,         0,32'h000, 1,32'h004);
    add(0,3, 1,1,1,32'h100,   0,32'h000, 0,32'h008);
    add(0,3, 1,1,0,0,         0,32'h000, 0,32'h100);
    add(0,3, 1,1,0,0,         0,32'h000, 1,32'h100);
    add(0,3, 1,1,0,0,         0,32'h000, 1,32'h104);
    add(0,3, 1,1,0,0,         0,32'h000, 0,32'h108);
    add(0,3, 1,1,0,0,         0,32'h000, 0,32'h108);
    add(0,3, 1,1,0,0,         1,32'h100, 1,32'h108);
    add(0,3, 1,1,0,0,         1,32'h104, 1,32'h10C);
    // Grant withheld 3 cycles, 3-cycle memory
    add(1,3, 0,1,0,0, 0,32'h00, 1,32'h00);
    add(0,3, 0,1,0,0, 0,32'h00, 1,32'h00);
    add(0,3, 0,1,0,0, 0,32'h00, 1,32'h00);
    add(0,3, 1,1,0,0, 0,32'h00, 1,32'h00);
    add(0,3, 1,1,0,0, 0,32'h00, 1,32'h04);
    add(0,3, 1,1,0,0, 0,32'h00, 0,32'h08);
    add(0,3, 1,1,0,0, 0,32'h00, 0,32'h08);
    add(0,3, 1,1,0,0, 1,32'h00, 1,32'h08);
    add(0,3, 1,1,0,0, 1,32'h04, 1,32'h0C);
    add(0,3, 1,1,0,0, 0,32'h00, 0,32'h10);
    add(0,3, 1,1,0,0, 0,32'h00, 0,32'h10);
    add(0,3, 1,1,0,0, 1,32'h08, 1,32'h10);
    add(0,3, 1,1,0,0, 1,32'h0C, 1,32'h14);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(vecs[i].lat);
      step(vecs[i].gnt, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      chk_out($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ereq, vecs[i].eaddr);
    end

    // Redirect coinciding with a response and a pop
    do_reset(1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);           chk_out("rdpop c2", 1, 32'h0, 1, 32'h8);
    step(1, 1, 1, 32'h200);     chk_out("rdpop c3", 1, 32'h4, 0, 32'hC);
    step(1, 1, 0, 0);           chk_out("rdpop c4", 0, 32'h0, 1, 32'h200);
    step(1, 1, 0, 0);           chk_out("rdpop c5", 0, 32'h0, 1, 32'h204);
    step(1, 1, 0, 0);           chk_out("rdpop c6", 1, 32'h200, 1, 32'h208);
    step(1, 1, 0, 0);           chk_out("rdpop c7", 1, 32'h204, 1, 32'h20C);
    step(1, 1, 0, 0);           chk_out("rdpop c8", 1, 32'h208, 1, 32'h210);

    // PC wrap at top of address space, unaligned redirect target
    do_reset(1);
    step(1, 1, 1, 32'hFFFF_FFFE); chk_out("wrap c0", 0, 32'h0, 0, 32'h0);
    step(1, 1, 0, 0);             chk_out("wrap c1", 0, 32'h0, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);             chk_out("wrap c2", 0, 32'h0, 1, 32'h0);
    step(1, 1, 0, 0);             chk_out("wrap c3", 1, 32'hFFFF_FFFC, 1, 32'h4);
    step(1, 1, 1, 32'h103);       chk_out("wrap c4", 1, 32'h0, 0, 32'h8);
    step(1, 1, 0, 0);             chk_out("wrap c5", 0, 32'h0, 1, 32'h100);
    step(1, 1, 0, 0);             chk_out("wrap c6", 0, 32'h0, 1, 32'h104);
    step(1, 1, 0, 0);             chk_out("wrap c7", 1, 32'h100, 1, 32'h108);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("midrst instr", bus.instr, 32'd0);
    chk("midrst pc", bus.pc, 32'd0);
    chk("midrst addr", bus.imem_addr, 32'd0);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
